// File: rtl/ksa_mp_add_seq.sv
// ksa_mp_add_seq
//   Multi-precision add sequencer placed in front of a combinational W-bit
//   adder. Operand word pairs arrive least-significant word first. Each word
//   is held in an operand register (stage 1) that drives the adder. The adder
//   result is captured into an output register (stage 2). The carry of each
//   word feeds the carry-in of the next word of the same operation.
//   One operation is NWORDS words. Throughput is one word per clock.
//
// Ports
//   clk, rst             clock; synchronous active-high reset
//   in_valid/in_ready    operand stream handshake
//   in_a, in_b, in_cin   operand words; in_cin is sampled only on word 0
//   add_x, add_y,        to the adder (add_x/add_y are the operand register)
//   add_cin
//   add_sum, add_cout    from the adder (combinational from add_x/y/cin)
//   out_valid/out_ready  result stream handshake
//   out_sum, out_idx,    result word, its index (0 = LS word), last flag and
//   out_last, out_cout   final carry (non-zero only with out_last)
//   busy                 an operation is partially accepted or still in flight
module ksa_mp_add_seq #(
  parameter int W      = 64,
  parameter int NWORDS = 4,
  parameter int IDX_W  = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [W-1:0]     in_a,
  input  logic [W-1:0]     in_b,
  input  logic             in_cin,
  output logic [W-1:0]     add_x,
  output logic [W-1:0]     add_y,
  output logic             add_cin,
  input  logic [W-1:0]     add_sum,
  input  logic             add_cout,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [W-1:0]     out_sum,
  output logic [IDX_W-1:0] out_idx,
  output logic             out_last,
  output logic             out_cout,
  output logic             busy
);

  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NWORDS - 1);

  // Busy decode: IDLE only when no word is counted or held anywhere.
  localparam logic [0:0] ST_IDLE   = 1'b0;
  localparam logic [0:0] ST_ACCEPT = 1'b1;

  // Stage 1: operand register
  logic [W-1:0]     op_a_q, op_a_d;
  logic [W-1:0]     op_b_q, op_b_d;
  logic             op_cin_q, op_cin_d;
  logic [IDX_W-1:0] op_idx_q, op_idx_d;
  logic             op_first_q, op_first_d;
  logic             op_vld_q, op_vld_d;

  // Stage 2: output register
  logic [W-1:0]     out_sum_q, out_sum_d;
  logic [IDX_W-1:0] out_idx_q, out_idx_d;
  logic             out_last_q, out_last_d;
  logic             out_cout_q, out_cout_d;
  logic             out_valid_q, out_valid_d;

  // Carry of the last word moved into stage 2, and input word counter
  logic             carry_q, carry_d;
  logic [IDX_W-1:0] in_idx_q, in_idx_d;

  logic             adv;
  logic             in_xfer;
  logic             op_last;
  logic             in_first;
  logic [0:0]       state;

  // Stage 1 may move on when stage 2 is empty or being emptied this cycle,
  // which gives bubble-free flow under continuous out_ready.
  assign adv      = op_vld_q && (!out_valid_q || out_ready);
  assign in_ready = !op_vld_q || adv;
  assign in_xfer  = in_valid && in_ready;
  assign op_last  = (op_idx_q == LAST_IDX);
  assign in_first = (in_idx_q == '0);

  // Word 0 takes the operation carry-in; later words take the chained carry.
  assign add_x   = op_a_q;
  assign add_y   = op_b_q;
  assign add_cin = op_first_q ? op_cin_q : carry_q;

  assign out_valid = out_valid_q;
  assign out_sum   = out_sum_q;
  assign out_idx   = out_idx_q;
  assign out_last  = out_last_q;
  assign out_cout  = out_cout_q;

  always_comb begin
    state = (in_first && !op_vld_q && !out_valid_q) ? ST_IDLE : ST_ACCEPT;
  end

  assign busy = (state == ST_ACCEPT);

  // NOTE: every next-state variable gets its hold value first, so no path
  // through this block leaves one unassigned and no latch is inferred.
  always_comb begin
    op_a_d      = op_a_q;
    op_b_d      = op_b_q;
    op_cin_d    = op_cin_q;
    op_idx_d    = op_idx_q;
    op_first_d  = op_first_q;
    op_vld_d    = op_vld_q;
    out_sum_d   = out_sum_q;
    out_idx_d   = out_idx_q;
    out_last_d  = out_last_q;
    out_cout_d  = out_cout_q;
    out_valid_d = out_valid_q;
    carry_d     = carry_q;
    in_idx_d    = in_idx_q;

    if (in_xfer) begin
      op_a_d     = in_a;
      op_b_d     = in_b;
      op_idx_d   = in_idx_q;
      op_first_d = in_first;
      op_cin_d   = in_first ? in_cin : 1'b0;
      op_vld_d   = 1'b1;
      in_idx_d   = (in_idx_q == LAST_IDX) ? '0 : in_idx_q + IDX_W'(1);
    end else if (adv) begin
      op_vld_d = 1'b0;
    end

    if (adv) begin
      out_sum_d   = add_sum;
      out_idx_d   = op_idx_q;
      out_last_d  = op_last;
      // The carry out of the top word leaves only through out_cout.
      out_cout_d  = op_last & add_cout;
      carry_d     = add_cout;
      out_valid_d = 1'b1;
    end else if (out_valid_q && out_ready) begin
      out_valid_d = 1'b0;
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values; datapath registers are reset as well because
  // the outputs are required to read 0 after reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      op_a_q      <= '0;
      op_b_q      <= '0;
      op_cin_q    <= 1'b0;
      op_idx_q    <= '0;
      op_first_q  <= 1'b0;
      op_vld_q    <= 1'b0;
      out_sum_q   <= '0;
      out_idx_q   <= '0;
      out_last_q  <= 1'b0;
      out_cout_q  <= 1'b0;
      out_valid_q <= 1'b0;
      carry_q     <= 1'b0;
      in_idx_q    <= '0;
    end else begin
      op_a_q      <= op_a_d;
      op_b_q      <= op_b_d;
      op_cin_q    <= op_cin_d;
      op_idx_q    <= op_idx_d;
      op_first_q  <= op_first_d;
      op_vld_q    <= op_vld_d;
      out_sum_q   <= out_sum_d;
      out_idx_q   <= out_idx_d;
      out_last_q  <= out_last_d;
      out_cout_q  <= out_cout_d;
      out_valid_q <= out_valid_d;
      carry_q     <= carry_d;
      in_idx_q    <= in_idx_d;
    end
  end

endmodule

// File: tb/tb_ksa_mp_add_seq.sv
// tb_ksa_mp_add_seq
//   Bench for ksa_mp_add_seq. It contains two instances. One is the NWORDS=4
//   default. The other is an NWORDS=1 instance used for the single-word case.
//   Each instance gets a behavioural W-bit adder. Each whole operation is
//   modelled as one wide addition A+B+cin. The expected words are queued when
//   the operation is issued, and a monitor pops and compares them on every
//   output handshake.
module tb_ksa_mp_add_seq;

  localparam int W  = 64;
  localparam int NW = 4;
  localparam int IW = 2;

  typedef logic [W:0] val_t;
  typedef struct packed {
    logic [W-1:0]  sum;
    logic [IW-1:0] idx;
    logic          last;
    logic          cout;
  } exp_t;

  logic          clk;
  logic          rst;

  // NWORDS = 4 instance
  logic          in_valid, in_ready, in_cin;
  logic [W-1:0]  in_a, in_b;
  logic [W-1:0]  add_x, add_y, add_sum;
  logic          add_cin, add_cout;
  logic          out_valid, out_ready, out_last, out_cout, busy;
  logic [W-1:0]  out_sum;
  logic [IW-1:0] out_idx;

  // NWORDS = 1 instance
  logic          in_valid1, in_ready1, in_cin1;
  logic [W-1:0]  in_a1, in_b1;
  logic [W-1:0]  add_x1, add_y1, add_sum1;
  logic          add_cin1, add_cout1;
  logic          out_valid1, out_ready1, out_last1, out_cout1, busy1;
  logic [W-1:0]  out_sum1;
  logic [0:0]    out_idx1;

  int   n_checks = 0;
  int   n_pass   = 0;
  exp_t exp_q[$];
  int   ready_mode = 0;   // 0: always ready, 1: random, 2: man_ready
  logic man_ready  = 1'b1;

  ksa_mp_add_seq #(.W(W), .NWORDS(NW), .IDX_W(IW)) u_dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_a(in_a), .in_b(in_b), .in_cin(in_cin),
    .add_x(add_x), .add_y(add_y), .add_cin(add_cin),
    .add_sum(add_sum), .add_cout(add_cout),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_sum(out_sum), .out_idx(out_idx), .out_last(out_last),
    .out_cout(out_cout), .busy(busy)
  );

  ksa_mp_add_seq #(.W(W), .NWORDS(1), .IDX_W(1)) u_dut1 (
    .clk(clk), .rst(rst),
    .in_valid(in_valid1), .in_ready(in_ready1),
    .in_a(in_a1), .in_b(in_b1), .in_cin(in_cin1),
    .add_x(add_x1), .add_y(add_y1), .add_cin(add_cin1),
    .add_sum(add_sum1), .add_cout(add_cout1),
    .out_valid(out_valid1), .out_ready(out_ready1),
    .out_sum(out_sum1), .out_idx(out_idx1), .out_last(out_last1),
    .out_cout(out_cout1), .busy(busy1)
  );

  // Behavioural W-bit adders
  assign {add_cout, add_sum}   = {1'b0, add_x} + {1'b0, add_y} + {{W{1'b0}}, add_cin};
  assign {add_cout1, add_sum1} = {1'b0, add_x1} + {1'b0, add_y1} + {{W{1'b0}}, add_cin1};

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input val_t act, input val_t exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask

  // out_ready driver: changes only just after a rising edge
  initial begin
    out_ready = 1'b1;
    forever begin
      @(posedge clk);
      #1;
      case (ready_mode)
        0:       out_ready = 1'b1;
        1:       out_ready = ($urandom_range(0, 3) != 0);
        default: out_ready = man_ready;
      endcase
    end
  end

  // Monitor: a handshake seen at the falling edge completes at the next rise
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (!rst && out_valid && out_ready) begin
        if (exp_q.size() == 0) begin
          check("sb word expected", val_t'(exp_q.size()), val_t'(1));
        end else begin
          e = exp_q.pop_front();
          check($sformatf("sb sum idx%0d", e.idx), val_t'(out_sum), val_t'(e.sum));
          check("sb idx", val_t'(out_idx), val_t'(e.idx));
          check($sformatf("sb last idx%0d", e.idx), val_t'(out_last), val_t'(e.last));
          check($sformatf("sb cout idx%0d", e.idx), val_t'(out_cout), val_t'(e.cout));
        end
      end
    end
  end

  function automatic logic [NW*W-1:0] rand_op();
    logic [NW*W-1:0] r;
    for (int i = 0; i < NW*W/32; i++) r[i*32 +: 32] = $urandom;
    if ($urandom_range(0, 7) == 0) r = '1;
    return r;
  endfunction

  // Called and returns just after a rising edge.
  task automatic send_word(input logic [W-1:0] a, input logic [W-1:0] b,
                           input logic cin, input int max_gap);
    int gap;
    int waited;
    gap = $urandom_range(0, max_gap);
    if (gap > 0) begin
      repeat (gap) @(posedge clk);
      #1;
    end
    in_valid = 1'b1;
    in_a     = a;
    in_b     = b;
    in_cin   = cin;
    waited   = 0;
    @(negedge clk);
    while (!in_ready && waited < 200) begin
      @(negedge clk);
      waited++;
    end
    check("in_ready wait", val_t'(in_ready), val_t'(1));
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    in_a     = W'($urandom);
    in_b     = W'($urandom);
    in_cin   = 1'($urandom);
  endtask

  // Reference model: the whole operation is one (NW*W+1)-bit addition.
  task automatic send_op(input logic [NW*W-1:0] a_all, input logic [NW*W-1:0] b_all,
                         input logic cin, input bit push, input int max_gap);
    logic [NW*W:0] full;
    full = {1'b0, a_all} + {1'b0, b_all} + {{(NW*W){1'b0}}, cin};
    if (push) begin
      for (int i = 0; i < NW; i++) begin
        exp_q.push_back('{sum:  full[i*W +: W],
                          idx:  IW'(i),
                          last: (i == NW-1),
                          cout: (i == NW-1) ? full[NW*W] : 1'b0});
      end
    end
    for (int i = 0; i < NW; i++) begin
      // in_cin on words other than 0 is noise that must be ignored
      send_word(a_all[i*W +: W], b_all[i*W +: W], (i == 0) ? cin : 1'($urandom), max_gap);
    end
  endtask

  task automatic drain();
    int w;
    w = 0;
    while (exp_q.size() != 0 && w < 500) begin
      @(negedge clk);
      w++;
    end
    check("drain queue empty", val_t'(exp_q.size()), val_t'(0));
    @(posedge clk);
    #1;
  endtask

  initial begin
    logic [NW*W-1:0] ones;
    int w;
    ones       = '1;
    rst        = 1'b1;
    in_valid   = 1'b0;
    in_a       = '0;
    in_b       = '0;
    in_cin     = 1'b0;
    in_valid1  = 1'b0;
    in_a1      = '0;
    in_b1      = '0;
    in_cin1    = 1'b0;
    out_ready1 = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;

    // Reset state
    @(negedge clk);
    check("rst out_valid", val_t'(out_valid), val_t'(0));
    check("rst in_ready", val_t'(in_ready), val_t'(1));
    check("rst busy", val_t'(busy), val_t'(0));
    check("rst out_sum", val_t'(out_sum), val_t'(0));
    check("rst out_cout", val_t'(out_cout), val_t'(0));
    check("rst out_last", val_t'(out_last), val_t'(0));
    check("rst1 in_ready", val_t'(in_ready1), val_t'(1));
    check("rst1 out_valid", val_t'(out_valid1), val_t'(0));
    @(posedge clk);
    #1;

    // T1: single word instance, result 2 clocks after accept
    in_valid1 = 1'b1;
    in_a1     = 64'hEEAAAABBEEAAAABB;
    in_b1     = 64'hEEAAAABBEEAAAABB;
    in_cin1   = 1'b0;
    @(negedge clk);
    check("t1 in_ready", val_t'(in_ready1), val_t'(1));
    @(posedge clk);
    #1;
    in_valid1 = 1'b0;
    @(negedge clk);
    check("t1 valid after 1 clk", val_t'(out_valid1), val_t'(0));
    check("t1 busy", val_t'(busy1), val_t'(1));
    @(negedge clk);
    check("t1 valid after 2 clk", val_t'(out_valid1), val_t'(1));
    check("t1 sum", val_t'(out_sum1), val_t'(64'hDD555577DD555576));
    check("t1 cout", val_t'(out_cout1), val_t'(1));
    check("t1 last", val_t'(out_last1), val_t'(1));
    check("t1 idx", val_t'(out_idx1), val_t'(0));
    @(negedge clk);
    check("t1 valid cleared", val_t'(out_valid1), val_t'(0));
    check("t1 idle", val_t'(busy1), val_t'(0));
    @(posedge clk);
    #1;

    // T2: carry ripple through all words
    send_op(ones, {{(NW*W-1){1'b0}}, 1'b1}, 1'b0, 1'b1, 0);
    drain();

    // T3: carry-in use, then no carry leak into the next operation
    send_op('0, '0, 1'b1, 1'b1, 0);
    send_op('0, '0, 1'b0, 1'b1, 0);
    drain();

    // T4: backpressure for 3 clocks after the first out_valid
    ready_mode = 2;
    man_ready  = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    fork
      send_op(ones, {{(NW*W-1){1'b0}}, 1'b1}, 1'b0, 1'b1, 0);
      begin
        w = 0;
        @(negedge clk);
        while (!out_valid && w < 50) begin
          @(negedge clk);
          w++;
        end
        check("t4 first valid", val_t'(out_valid), val_t'(1));
        check("t4 stage1 full", val_t'(in_ready), val_t'(0));
        for (int c = 0; c < 3; c++) begin
          @(negedge clk);
          check("t4 hold valid", val_t'(out_valid), val_t'(1));
          check("t4 hold sum", val_t'(out_sum), val_t'(exp_q[0].sum));
          check("t4 hold idx", val_t'(out_idx), val_t'(exp_q[0].idx));
          check("t4 hold last", val_t'(out_last), val_t'(exp_q[0].last));
          check("t4 hold cout", val_t'(out_cout), val_t'(exp_q[0].cout));
          check("t4 in_ready low", val_t'(in_ready), val_t'(0));
        end
        man_ready = 1'b1;
      end
    join
    ready_mode = 0;
    drain();

    // T5: reset after 2 of 4 words, nothing may come out
    ready_mode = 2;
    man_ready  = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    send_word(W'($urandom), W'($urandom), 1'b1, 0);
    send_word(W'($urandom), W'($urandom), 1'b0, 0);
    rst = 1'b1;
    @(negedge clk);
    check("t5 busy before reset", val_t'(busy), val_t'(1));
    @(posedge clk);
    #1;
    rst = 1'b0;
    @(negedge clk);
    check("t5 out_valid", val_t'(out_valid), val_t'(0));
    check("t5 busy", val_t'(busy), val_t'(0));
    check("t5 in_ready", val_t'(in_ready), val_t'(1));
    ready_mode = 0;
    repeat (2) @(posedge clk);
    #1;
    send_op(rand_op(), rand_op(), 1'b1, 1'b1, 1);
    drain();

    // T6: random operations with input gaps and output stalls
    ready_mode = 1;
    for (int n = 0; n < 1000; n++) begin
      send_op(rand_op(), rand_op(), 1'($urandom), 1'b1, 2);
    end
    drain();
    ready_mode = 0;

    check("final queue empty", val_t'(exp_q.size()), val_t'(0));
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
